// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame shadow latching,
// anti-ghost blanking after each digit step, per-digit blink and decimal point.
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 16,
  parameter int BLANK_CYC = 64,
  parameter int BLINK_DIV = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic        hi_sel,
  input  logic [31:0] Disp_num,
  input  logic [3:0]  point_in,
  input  logic [3:0]  blink_in,
  output logic [3:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        frame_tick
);

  localparam int BW = (BLANK_CYC < 1) ? 1 : $clog2(BLANK_CYC + 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYC);

  logic [SCAN_DIV-1:0]  presc;
  logic [1:0]           d;
  logic [BW-1:0]        blank_cnt;
  logic [BLINK_DIV-1:0] blink_cnt;

  logic        sh_hi;
  logic [31:0] sh_num;
  logic [3:0]  sh_point;
  logic [3:0]  sh_blink;

  logic        scan_tick;
  logic        wrap;
  logic [15:0] half;
  logic [3:0]  nib;
  logic [3:0]  an_next;
  logic [7:0]  seg_next;

  function automatic logic [6:0] decode(input logic [3:0] value);
    logic [6:0] code;
    case (value)
      4'h0: code = 7'h40;
      4'h1: code = 7'h79;
      4'h2: code = 7'h24;
      4'h3: code = 7'h30;
      4'h4: code = 7'h19;
      4'h5: code = 7'h12;
      4'h6: code = 7'h02;
      4'h7: code = 7'h78;
      4'h8: code = 7'h00;
      4'h9: code = 7'h10;
      4'hA: code = 7'h08;
      4'hB: code = 7'h03;
      4'hC: code = 7'h46;
      4'hD: code = 7'h21;
      4'hE: code = 7'h06;
      default: code = 7'h0E;
    endcase
    return code;
  endfunction

  assign scan_tick = (presc == '1) & EN;
  assign wrap      = scan_tick & (d == 2'd3);

  // Every counter freezes while EN is low so scanning resumes exactly where it stopped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc     <= '0;
      d         <= '0;
      blank_cnt <= '0;
      blink_cnt <= '0;
    end else if (EN) begin
      presc     <= presc + SCAN_DIV'(1);
      blink_cnt <= blink_cnt + BLINK_DIV'(1);
      if (scan_tick) begin
        d         <= d + 2'd1;
        blank_cnt <= BLANK_LOAD;
      end else if (blank_cnt != '0) begin
        blank_cnt <= blank_cnt - BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_hi    <= 1'b0;
      sh_num   <= '0;
      sh_point <= '0;
      sh_blink <= '0;
    end else if (wrap) begin
      sh_hi    <= hi_sel;
      sh_num   <= Disp_num;
      sh_point <= point_in;
      sh_blink <= blink_in;
    end
  end

  // Blink only gates the anode; cathodes keep the digit pattern throughout.
  always_comb begin
    half     = sh_hi ? sh_num[31:16] : sh_num[15:0];
    nib      = 4'(half >> {d, 2'b00});
    seg_next = {~sh_point[d], decode(nib)};
    an_next  = ~(4'b0001 << d);
    if ((blank_cnt != '0) || (blink_cnt[BLINK_DIV-1] && sh_blink[d])) begin
      an_next = 4'hF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      AN         <= 4'hF;
      SEGMENT    <= 8'hFF;
      frame_tick <= 1'b0;
    end else if (EN) begin
      AN         <= an_next;
      SEGMENT    <= seg_next;
      frame_tick <= wrap;
    end else begin
      AN         <= 4'hF;
      SEGMENT    <= 8'hFF;
      frame_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: an enabled-cycle-count model predicts
// every output each cycle, with literal checks pinning the scan, latch and reset behaviour.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV     = 2;
  localparam int BLANK_CYC    = 1;
  localparam int BLINK_DIV    = 4;
  localparam int STEP         = 1 << SCAN_DIV;
  localparam int FRAME        = 4 * STEP;
  localparam int BLINK_PERIOD = 1 << BLINK_DIV;

  localparam logic [7:0] SEG_TBL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk;
  logic        rst;
  logic        EN;
  logic        hi_sel;
  logic [31:0] Disp_num;
  logic [3:0]  point_in;
  logic [3:0]  blink_in;
  logic [3:0]  AN;
  logic [7:0]  SEGMENT;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;
  bit armed    = 0;

  int          n;
  logic        m_hi;
  logic [31:0] m_num;
  logic [3:0]  m_point;
  logic [3:0]  m_blink;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;
  logic        exp_ft;

  seg7_scan_driver #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .EN        (EN),
    .hi_sel    (hi_sel),
    .Disp_num  (Disp_num),
    .point_in  (point_in),
    .blink_in  (blink_in),
    .AN        (AN),
    .SEGMENT   (SEGMENT),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model state is just the number of enabled edges since reset plus the shadows.
  function automatic logic [3:0] model_an(input int cnt, input logic [3:0] blk);
    int dd;
    bit blanked;
    bit blink_on;
    dd       = (cnt / STEP) % 4;
    blanked  = (cnt >= STEP) && ((cnt % STEP) < BLANK_CYC);
    blink_on = (cnt % BLINK_PERIOD) >= (BLINK_PERIOD / 2);
    if (blanked || (blink_on && blk[dd])) return 4'hF;
    return ~(4'b0001 << dd);
  endfunction

  function automatic logic [7:0] model_seg(input int cnt, input logic hi, input logic [31:0] num,
                                           input logic [3:0] pt);
    int dd;
    logic [15:0] half;
    logic [3:0]  nib;
    logic [7:0]  code;
    dd   = (cnt / STEP) % 4;
    half = hi ? num[31:16] : num[15:0];
    nib  = half[dd*4 +: 4];
    code = SEG_TBL[nib];
    return {~pt[dd], code[6:0]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n       <= 0;
      m_hi    <= 1'b0;
      m_num   <= '0;
      m_point <= '0;
      m_blink <= '0;
      exp_an  <= 4'hF;
      exp_seg <= 8'hFF;
      exp_ft  <= 1'b0;
    end else if (!EN) begin
      exp_an  <= 4'hF;
      exp_seg <= 8'hFF;
      exp_ft  <= 1'b0;
    end else begin
      exp_an  <= model_an(n, m_blink);
      exp_seg <= model_seg(n, m_hi, m_num, m_point);
      exp_ft  <= ((n % FRAME) == FRAME - 1);
      if ((n % FRAME) == FRAME - 1) begin
        m_hi    <= hi_sel;
        m_num   <= Disp_num;
        m_point <= point_in;
        m_blink <= blink_in;
      end
      n <= n + 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check_output("model_an", 32'(AN), 32'(exp_an));
      check_output("model_seg", 32'(SEGMENT), 32'(exp_seg));
      check_output("model_frame_tick", 32'(frame_tick), 32'(exp_ft));
    end
  end

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = frame_tick;
    end
    check_output("frame_seen", 32'(seen), 32'd1);
  endtask

  task automatic apply_stimulus(input logic en_v, input logic hi_v, input logic [31:0] num_v,
                                input logic [3:0] pt_v, input logic [3:0] blk_v);
    EN       = en_v;
    hi_sel   = hi_v;
    Disp_num = num_v;
    point_in = pt_v;
    blink_in = blk_v;
  endtask

  logic [3:0] seq_an  [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                               4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
  logic [7:0] seq_seg [16] = '{8'h99, 8'h99, 8'h99, 8'h99, 8'hB0, 8'hB0, 8'hB0, 8'hB0,
                               8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'hF9, 8'hF9, 8'hF9, 8'hF9};

  initial begin
    int cnt_b;
    int cnt_7;
    bit found;
    rst = 1'b1;
    apply_stimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 4'hF, 4'hF);
    #1 rst = 1'b0;
    armed = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset_an", 32'(AN), 32'hF);
    check_output("reset_seg", 32'(SEGMENT), 32'hFF);
    check_output("reset_ft", 32'(frame_tick), 32'd0);

    apply_stimulus(1'b1, 1'b0, 32'h0000_1234, 4'h0, 4'h0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_output("pre_step_an", 32'(AN), 32'hE);
    check_output("pre_step_seg", 32'(SEGMENT), 32'hC0);
    @(negedge clk);
    check_output("first_step_blank", 32'(AN), 32'hF);

    // Scan order after the first latch of 0x1234.
    wait_frame();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check_output("scan_an", 32'(AN), 32'(seq_an[k]));
      check_output("scan_seg", 32'(SEGMENT), 32'(seq_seg[k]));
    end

    // Mid-frame change of half/point must wait for the next latch.
    apply_stimulus(1'b1, 1'b1, 32'hABCD_0000, 4'b0001, 4'h0);
    repeat (2) @(negedge clk);
    check_output("midframe_old_an", 32'(AN), 32'hE);
    check_output("midframe_old_seg", 32'(SEGMENT), 32'h99);
    wait_frame();
    repeat (2) @(negedge clk);
    check_output("hi_digit0_an", 32'(AN), 32'hE);
    check_output("hi_digit0_seg", 32'(SEGMENT), 32'h21);
    repeat (12) @(negedge clk);
    check_output("hi_digit3_an", 32'(AN), 32'h7);
    check_output("hi_digit3_seg", 32'(SEGMENT), 32'h88);

    // Digit 2 blinks; its slot coincides with blink MSB=1 at these parameters.
    apply_stimulus(1'b1, 1'b1, 32'hABCD_0000, 4'b0001, 4'b0100);
    wait_frame();
    cnt_b = 0;
    cnt_7 = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (AN == 4'hB) cnt_b++;
      if (AN == 4'h7) cnt_7++;
    end
    check_output("blink_digit2_hidden", 32'(cnt_b), 32'd0);
    check_output("blink_other_visible", 32'(cnt_7 != 0), 32'd1);
    apply_stimulus(1'b1, 1'b1, 32'hABCD_0000, 4'b0001, 4'b0000);
    wait_frame();

    // EN low mid-digit.
    repeat (2) @(negedge clk);
    EN = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_output("en_off_an", 32'(AN), 32'hF);
      check_output("en_off_seg", 32'(SEGMENT), 32'hFF);
      check_output("en_off_ft", 32'(frame_tick), 32'd0);
    end
    EN = 1'b1;
    repeat (20) @(negedge clk);

    // Async reset between edges while digit 2 is active.
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      found = (((n / STEP) % 4) == 2);
    end
    check_output("reach_digit2", 32'(found), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("async_rst_an", 32'(AN), 32'hF);
    check_output("async_rst_seg", 32'(SEGMENT), 32'hFF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("post_rst_an", 32'(AN), 32'hE);
    check_output("post_rst_seg", 32'(SEGMENT), 32'hC0);

    // Randomized traffic, including one extra async reset.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        apply_stimulus(($urandom_range(0, 9) != 0), 1'($urandom), $urandom,
                       4'($urandom), 4'($urandom));
      end else begin
        EN = ($urandom_range(0, 9) != 0);
      end
      if (i == 400) begin
        @(posedge clk);
        #($urandom_range(1, 4)) rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
